// File: rtl/inst_encoder.sv
// RV32I instruction packer: fields + signed immediate in, range-checked word plus load address out.
// Latency 1 cycle through one output register; in_ready = !out_valid || out_ready.
module inst_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ADDR_STEP = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        restart,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic [7:0]  err_count
);

    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_LUI    = 7'b011_0111;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;
    localparam logic [31:0] INST_NOP  = 32'h0000_0013;

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic [31:0] out_addr_q, out_addr_d;
    logic        out_err_q, out_err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [31:0] addr_cnt_q, addr_cnt_d;

    logic        xfer, out_hs;
    logic [31:0] enc_inst;
    logic        enc_err;

    logic signed [31:0] imm_s;
    logic imm12_ok, shamt_ok, br_ok, jal_ok, upper_ok;

    assign imm_s    = imm;
    assign imm12_ok = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
    assign shamt_ok = (imm_s >= 32'sd0) && (imm_s <= 32'sd31);
    assign br_ok    = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !imm[0];
    assign jal_ok   = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !imm[0];
    assign upper_ok = (imm[11:0] == 12'h000);

    // Out-of-range immediates are still packed from their low bits; only the flag marks them.
    always_comb begin
        enc_inst = INST_NOP;
        enc_err  = 1'b1;
        case (opcode)
            OPC_LOAD, OPC_JALR: begin
                enc_inst = {imm[11:0], rs1, funct3, rd, opcode};
                enc_err  = !imm12_ok;
            end
            OPC_OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    enc_inst = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                    enc_err  = !shamt_ok;
                end else begin
                    enc_inst = {imm[11:0], rs1, funct3, rd, opcode};
                    enc_err  = !imm12_ok;
                end
            end
            OPC_STORE: begin
                enc_inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                enc_err  = !imm12_ok;
            end
            OPC_BRANCH: begin
                enc_inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                enc_err  = !br_ok;
            end
            OPC_LUI, OPC_AUIPC: begin
                enc_inst = {imm[31:12], rd, opcode};
                enc_err  = !upper_ok;
            end
            OPC_JAL: begin
                enc_inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                enc_err  = !jal_ok;
            end
            OPC_OP: begin
                enc_inst = {funct7, rs2, rs1, funct3, rd, opcode};
                enc_err  = 1'b0;
            end
            default: begin
                enc_inst = INST_NOP;
                enc_err  = 1'b1;
            end
        endcase
    end

    assign in_ready = !out_valid_q || out_ready;
    assign xfer     = in_valid && in_ready;
    assign out_hs   = out_valid_q && out_ready;

    // A word accepted this cycle takes the post-update counter, so back-to-back words step by ADDR_STEP.
    always_comb begin
        addr_cnt_d = addr_cnt_q;
        if (restart) begin
            addr_cnt_d = BASE_ADDR;
        end else if (out_hs) begin
            addr_cnt_d = addr_cnt_q + ADDR_STEP;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_addr_d  = out_addr_q;
        out_err_d   = out_err_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_inst_d  = enc_inst;
            out_addr_d  = addr_cnt_d;
            out_err_d   = enc_err;
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (out_hs && out_err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_inst_q  <= 32'h0000_0000;
            out_addr_q  <= BASE_ADDR;
            out_err_q   <= 1'b0;
            err_cnt_q   <= 8'h00;
            addr_cnt_q  <= BASE_ADDR;
        end else begin
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_addr_q  <= out_addr_d;
            out_err_q   <= out_err_d;
            err_cnt_q   <= err_cnt_d;
            addr_cnt_q  <= addr_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_inst  = out_inst_q;
    assign out_addr  = out_addr_q;
    assign out_err   = out_err_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed vectors, immediate boundaries, backpressure, restart, random traffic.
module tb_inst_encoder;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] STEP = 32'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        restart = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [6:0]  opcode = 7'h00;
    logic [4:0]  rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [6:0]  funct7 = 7'd0;
    logic [31:0] imm = 32'd0;
    logic        in_ready, out_valid, out_err;
    logic [31:0] out_inst, out_addr;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    // Reference state: the word the encoder should be presenting, and the load-address counter.
    bit          m_vld;
    bit          m_err;
    logic [31:0] m_inst, m_addr, m_next;
    int          m_errcnt;

    inst_encoder #(.BASE_ADDR(BASE), .ADDR_STEP(STEP)) dut (
        .clk(clk), .rst(rst), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr),
        .out_err(out_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fld(input logic [31:0] x, input int lo, input int n);
        return (x >> lo) & ((32'd1 << n) - 32'd1);
    endfunction

    function automatic void model_encode(input logic [6:0] op, input logic [4:0] d, s1, s2,
                                         input logic [2:0] f3, input logic [6:0] f7,
                                         input logic [31:0] im,
                                         output logic [31:0] w, output bit e);
        int v;
        logic [31:0] o, rdv, f3v, r1v, r2v, f7v;
        v   = $signed(im);
        o   = 32'(op);
        rdv = 32'(d) << 7;
        f3v = 32'(f3) << 12;
        r1v = 32'(s1) << 15;
        r2v = 32'(s2) << 20;
        f7v = 32'(f7) << 25;
        case (op)
            7'h03, 7'h67: begin
                w = (fld(im, 0, 12) << 20) | r1v | f3v | rdv | o;
                e = (v < -2048) || (v > 2047);
            end
            7'h13: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    w = f7v | (fld(im, 0, 5) << 20) | r1v | f3v | rdv | o;
                    e = (v < 0) || (v > 31);
                end else begin
                    w = (fld(im, 0, 12) << 20) | r1v | f3v | rdv | o;
                    e = (v < -2048) || (v > 2047);
                end
            end
            7'h23: begin
                w = (fld(im, 5, 7) << 25) | r2v | r1v | f3v | (fld(im, 0, 5) << 7) | o;
                e = (v < -2048) || (v > 2047);
            end
            7'h63: begin
                w = (fld(im, 12, 1) << 31) | (fld(im, 5, 6) << 25) | r2v | r1v | f3v
                  | (fld(im, 1, 4) << 8) | (fld(im, 11, 1) << 7) | o;
                e = (v < -4096) || (v > 4094) || (fld(im, 0, 1) != 0);
            end
            7'h37, 7'h17: begin
                w = (im & 32'hFFFF_F000) | rdv | o;
                e = (im % 32'd4096) != 0;
            end
            7'h6F: begin
                w = (fld(im, 20, 1) << 31) | (fld(im, 1, 10) << 21) | (fld(im, 11, 1) << 20)
                  | (fld(im, 12, 8) << 12) | rdv | o;
                e = (v < -1048576) || (v > 1048574) || (fld(im, 0, 1) != 0);
            end
            7'h33: begin
                w = f7v | r2v | r1v | f3v | rdv | o;
                e = 1'b0;
            end
            default: begin
                w = 32'h0000_0013;
                e = 1'b1;
            end
        endcase
    endfunction

    task automatic model_reset();
        m_vld = 0; m_err = 0; m_inst = 32'd0; m_addr = BASE; m_next = BASE; m_errcnt = 0;
    endtask

    // Advance one clock: update the reference from the inputs now applied, return at the next negedge.
    task automatic step();
        bit hs, xfer, e;
        logic [31:0] w, nxt;
        hs   = m_vld && out_ready;
        xfer = in_valid && (!m_vld || out_ready);
        nxt  = restart ? BASE : (hs ? m_next + STEP : m_next);
        model_encode(opcode, rd, rs1, rs2, funct3, funct7, imm, w, e);
        if (hs && m_err && m_errcnt < 255) m_errcnt++;
        if (xfer) begin
            m_vld = 1; m_inst = w; m_err = e; m_addr = nxt;
        end else if (hs) begin
            m_vld = 0;
        end
        m_next = nxt;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input bit v, input logic [6:0] op, input logic [4:0] d, s1, s2,
                          input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
        in_valid = v; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    endtask

    task automatic rand_word();
        set_in(1'b1, ($urandom_range(0, 1) == 0) ? 7'h13 : 7'h33, 5'($urandom), 5'($urandom),
               5'($urandom), 3'($urandom_range(0, 7) & 6), 7'($urandom), 32'($urandom_range(0, 2047)));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_inst !== 32'd0 || out_err !== 1'b0 ||
            out_addr !== BASE || err_count !== 8'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: valid=%b inst=%h err=%b addr=%h cnt=%0d rdy=%b, required 0 0 0 %h 0 1",
                     out_valid, out_inst, out_err, out_addr, err_count, in_ready, BASE);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [6:0]  ops[5]  = '{7'h13, 7'h63, 7'h6F, 7'h37, 7'h23};
        logic [4:0]  rds[5]  = '{5'd1, 5'd31, 5'd1, 5'd5, 5'd7};
        logic [4:0]  r1s[5]  = '{5'd0, 5'd0, 5'd9, 5'd12, 5'd3};
        logic [4:0]  r2s[5]  = '{5'd17, 5'd0, 5'd4, 5'd6, 5'd2};
        logic [2:0]  f3s[5]  = '{3'd0, 3'd0, 3'd5, 3'd3, 3'd2};
        logic [31:0] ims[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0800, 32'h1234_5000, 32'h0000_0008};
        logic [31:0] exps[5] = '{32'hFFF0_0093, 32'hFE00_0EE3, 32'h0010_00EF, 32'h1234_52B7, 32'h0021_A423};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, ops[i], rds[i], r1s[i], r2s[i], f3s[i], 7'($urandom), ims[i]);
            step();
            checks++;
            if (out_valid !== 1'b1 || out_inst !== exps[i] || out_err !== 1'b0 ||
                out_addr !== BASE + STEP * 32'(i)) begin
                errors++;
                $display("FAIL directed[%0d]: valid=%b inst=%h err=%b addr=%h, required 1 %h 0 %h",
                         i, out_valid, out_inst, out_err, out_addr, exps[i], BASE + STEP * 32'(i));
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL directed_drain: out_valid=%b required 0", out_valid);
        end
    endtask

    typedef struct { logic [6:0] op; logic [2:0] f3; logic [31:0] im; bit err; } ev_t;

    task automatic test_errors();
        ev_t tv[$];
        int  delivered = 0;
        tv.push_back('{7'h13, 3'd0, 32'h0000_0800, 1'b1});
        tv.push_back('{7'h63, 3'd0, 32'h0000_0003, 1'b1});
        tv.push_back('{7'h7F, 3'd0, 32'h0000_0000, 1'b1});
        tv.push_back('{7'h13, 3'd0, 32'h0000_07FF, 1'b0});
        tv.push_back('{7'h13, 3'd0, 32'hFFFF_F800, 1'b0});
        tv.push_back('{7'h13, 3'd0, 32'hFFFF_F7FF, 1'b1});
        tv.push_back('{7'h13, 3'd1, 32'h0000_001F, 1'b0});
        tv.push_back('{7'h13, 3'd5, 32'h0000_0020, 1'b1});
        tv.push_back('{7'h13, 3'd1, 32'hFFFF_FFFF, 1'b1});
        tv.push_back('{7'h63, 3'd1, 32'h0000_0FFE, 1'b0});
        tv.push_back('{7'h63, 3'd1, 32'h0000_1000, 1'b1});
        tv.push_back('{7'h63, 3'd4, 32'hFFFF_F000, 1'b0});
        tv.push_back('{7'h63, 3'd4, 32'hFFFF_EFFE, 1'b1});
        tv.push_back('{7'h6F, 3'd0, 32'h000F_FFFE, 1'b0});
        tv.push_back('{7'h6F, 3'd0, 32'h0010_0000, 1'b1});
        tv.push_back('{7'h6F, 3'd0, 32'hFFF0_0000, 1'b0});
        tv.push_back('{7'h6F, 3'd0, 32'h0000_0005, 1'b1});
        tv.push_back('{7'h37, 3'd0, 32'h0000_1001, 1'b1});
        tv.push_back('{7'h17, 3'd0, 32'hFFFF_F000, 1'b0});
        tv.push_back('{7'h33, 3'd0, 32'hDEAD_BEEF, 1'b0});
        tv.push_back('{7'h23, 3'd2, 32'h0000_0800, 1'b1});
        tv.push_back('{7'h23, 3'd2, 32'hFFFF_F800, 1'b0});
        tv.push_back('{7'h00, 3'd0, 32'h0000_0000, 1'b1});
        out_ready = 1'b1;
        foreach (tv[i]) begin
            set_in(1'b1, tv[i].op, 5'd1, 5'd0, 5'd0, tv[i].f3, 7'd0, tv[i].im);
            step();
            checks++;
            if (out_err !== tv[i].err || out_inst !== m_inst || err_count !== 8'(delivered)) begin
                errors++;
                $display("FAIL imm_check[%0d]: err=%b inst=%h cnt=%0d, required %b %h %0d",
                         i, out_err, out_inst, err_count, tv[i].err, m_inst, delivered);
            end
            if (i == 0 || i == 2) begin
                checks++;
                if (out_inst !== ((i == 0) ? 32'h8000_0093 : 32'h0000_0013)) begin
                    errors++;
                    $display("FAIL err_word[%0d]: inst=%h required %h", i, out_inst,
                             (i == 0) ? 32'h8000_0093 : 32'h0000_0013);
                end
            end
            delivered += int'(tv[i].err);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (err_count !== 8'(delivered)) begin
            errors++;
            $display("FAIL err_count_after: got %0d required %0d", err_count, delivered);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] hold_inst, hold_addr;
        out_ready = 1'b1;
        rand_word();
        step();
        hold_inst = m_inst;
        hold_addr = m_addr;
        out_ready = 1'b0;
        rand_word();
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_in_ready[%0d]: got %b required 0", k, in_ready);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_inst !== hold_inst || out_addr !== hold_addr) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b inst=%h addr=%h, required 1 %h %h",
                         k, out_valid, out_inst, out_addr, hold_inst, hold_addr);
            end
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) rand_word();
            step();
            checks++;
            if (out_valid !== 1'b1 || out_inst !== m_inst || out_addr !== hold_addr + STEP * 32'(k + 1)) begin
                errors++;
                $display("FAIL bp_release[%0d]: valid=%b inst=%h addr=%h, required 1 %h %h",
                         k, out_valid, out_inst, out_addr, m_inst, hold_addr + STEP * 32'(k + 1));
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_restart();
        logic [31:0] want[4] = '{BASE, BASE + STEP, BASE, BASE + STEP};
        out_ready = 1'b1;
        rand_word();
        step();
        in_valid = 1'b0;
        restart  = 1'b1;
        step();
        restart  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rand_word();
            restart = (k == 2);
            step();
            restart = 1'b0;
            checks++;
            if (out_addr !== want[k] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL restart_addr[%0d]: addr=%h valid=%b, required %h 1", k, out_addr, out_valid, want[k]);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        restart   = 1'b1;
        step();
        restart   = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_addr !== BASE + STEP) begin
            errors++;
            $display("FAIL restart_pending: valid=%b addr=%h, required 1 %h", out_valid, out_addr, BASE + STEP);
        end
        out_ready = 1'b1;
        rand_word();
        step();
        checks++;
        if (out_addr !== BASE + STEP) begin
            errors++;
            $display("FAIL restart_after_pending: addr=%h required %h", out_addr, BASE + STEP);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_random();
        logic [6:0]  op_tab[10] = '{7'h03, 7'h13, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h7F};
        logic [31:0] im;
        for (int n = 0; n < 500; n++) begin
            case ($urandom_range(0, 3))
                0: im = 32'($urandom_range(0, 8191)) - 32'd4096;
                1: im = $urandom;
                2: im = $urandom & 32'hFFFF_F000;
                default: im = 32'($urandom_range(0, 63)) - 32'd16;
            endcase
            set_in($urandom_range(0, 3) != 0,
                   ($urandom_range(0, 15) == 0) ? 7'($urandom) : op_tab[$urandom_range(0, 9)],
                   5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), im);
            out_ready = ($urandom_range(0, 3) != 0);
            restart   = ($urandom_range(0, 31) == 0);
            #1;
            checks++;
            if (in_ready !== (!m_vld || out_ready)) begin
                errors++;
                $display("FAIL rand_in_ready[%0d]: got %b required %b", n, in_ready, !m_vld || out_ready);
            end
            step();
            restart = 1'b0;
            checks++;
            if (out_valid !== m_vld || err_count !== 8'(m_errcnt) ||
                (m_vld && (out_inst !== m_inst || out_err !== m_err || out_addr !== m_addr))) begin
                errors++;
                $display("FAIL rand[%0d]: valid=%b inst=%h err=%b addr=%h cnt=%0d, required %b %h %b %h %0d",
                         n, out_valid, out_inst, out_err, out_addr, err_count,
                         m_vld, m_inst, m_err, m_addr, m_errcnt);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        for (int n = 0; n < 270; n++) begin
            set_in(1'b1, 7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
            step();
            checks++;
            if (err_count !== 8'(m_errcnt)) begin
                errors++;
                $display("FAIL sat_count[%0d]: got %0d required %0d", n, err_count, m_errcnt);
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (err_count !== 8'd255) begin
            errors++;
            $display("FAIL sat_final: got %0d required 255", err_count);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        rand_word();
        step();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (out_valid !== 1'b0 || out_addr !== BASE || err_count !== 8'd0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b addr=%h cnt=%0d err=%b, required 0 %h 0 0",
                     out_valid, out_addr, err_count, out_err, BASE);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        rand_word();
        step();
        checks++;
        if (out_valid !== 1'b1 || out_addr !== BASE) begin
            errors++;
            $display("FAIL post_reset_addr: valid=%b addr=%h, required 1 %h", out_valid, out_addr, BASE);
        end
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_errors();
        test_backpressure();
        test_restart();
        test_random();
        test_saturation();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Inverse of the instruction immediate decoder. Accepts RV32I instruction fields plus a 32-bit signed immediate, range- and alignment-checks the immediate, and packs a 32-bit instruction word.
- Emits a program address alongside each word for loading instruction memory. Used by the boot/self-test loader and by the verification environment.
- Valid/ready on both sides; single registered output stage; 1-cycle latency.

Parameters:
- BASE_ADDR, 32'h0000_0000, address given to the first word after reset or `restart`.
- ADDR_STEP, 4, address increment per output handshake.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- restart  input  1  synchronous; reloads the address counter to BASE_ADDR.
- in_valid  input  1  input fields valid.
- in_ready  output  1  encoder can accept.
- opcode  input  7  RV32I major opcode.
- rd, rs1, rs2  input  5 each  register fields.
- funct3  input  3  funct3 field.
- funct7  input  7  funct7 field (R-type and shift-immediate).
- imm  input  32  signed immediate value, in byte units for B/J.
- out_valid  output  1  encoded word valid.
- out_ready  input  1  consumer accepts.
- out_inst  output  32  encoded instruction.
- out_addr  output  32  address of out_inst.
- out_err  output  1  word flagged as illegal encoding.
- err_count  output  8  saturating count of flagged words delivered.

Behaviour:
- Reset (async): out_valid=0, out_inst=0, out_err=0, out_addr=BASE_ADDR, err_count=0, address counter=BASE_ADDR.
- in_ready = !out_valid || out_ready (combinational). A transfer occurs when in_valid && in_ready.
- On a transfer: out_inst, out_err and out_addr=counter are registered next edge, and out_valid=1.
- On output handshake without a new transfer: out_valid=0.
- Counter increments by ADDR_STEP on each output handshake (out_valid && out_ready). It wraps modulo 2^32.
- Output regs hold stable while out_valid && !out_ready.
- restart: counter=BASE_ADDR. It has priority over the increment in the same cycle and does not disturb a pending output word. A new word accepted in the restart cycle gets BASE_ADDR.
- Encoding by opcode:
  - LOAD/JALR/OP_IMM: I-type, inst[31:20]=imm[11:0]; err if imm not in [-2048,2047].
  - OP_IMM with funct3 001/101: inst[31:25]=funct7, inst[24:20]=imm[4:0]; err if imm not in [0,31].
  - STORE: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0]; err if imm not in [-2048,2047].
  - BRANCH: inst[31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]; err if imm not in [-4096,4094] or imm[0]=1.
  - LUI/AUIPC: inst[31:12]=imm[31:12]; err if imm[11:0]!=0.
  - JAL: inst[31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]; err if imm not in [-2^20, 2^20-2] or imm[0]=1.
  - OP (R-type): imm ignored, never err.
  - Any other opcode: out_inst=32'h0000_0013 (NOP), err=1.
- Field placement: rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20] only where the format defines them. Undefined fields are 0; inputs for unused fields are ignored.
- On err the word is still encoded from the truncated imm bits (except unknown opcode) and delivered with out_err=1; no stall.
- err_count increments on each output handshake with out_err=1 and saturates at 255.
- Reset mid-operation discards any pending word; no handshake completes during rst.

Test Plan:
- Reset, then ADDI rd=1 rs1=0 f3=0 imm=32'hFFFF_FFFF, out_ready=1 -> next cycle out_valid=1, out_inst=32'hFFF0_0093, out_addr=0, out_err=0.
- BEQ rs1=0 rs2=0 imm=-4 -> 32'hFE00_0EE3. JAL rd=1 imm=2048 -> 32'h0010_00EF. Back-to-back transfers give addresses 0 and 4.
- LUI rd=5 imm=32'h1234_5000 -> 32'h1234_52B7. SW rs1=3 rs2=2 imm=8 -> 32'h0021_A423.
- ADDI rd=1 imm=2048 -> out_inst=32'h8000_0093, out_err=1, err_count=1. BRANCH imm=3 -> out_err=1. Opcode 7'h7F -> out_inst=32'h0000_0013, out_err=1. Counting continues until it saturates at 255.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_inst/out_addr stable, counter unchanged. Raising out_ready then gives one handshake per cycle with no loss or duplication. Assert rst mid-stream -> out_valid=0 immediately and next address=BASE_ADDR.
- restart asserted in the same cycle as an output handshake -> the next word's out_addr=BASE_ADDR, not previous+4.
